event_broker_mc: RTL

- Multi-channel, buffered successor to the single-event broker. Consumes the inbound AXI-Stream message channel from the ECD.
- Forwards AXI4-Lite response messages (type 0) through an internal response FIFO, so the input side is not stalled for each response.
- Decodes event messages (type 1) into EVENT_COUNT one-cycle strobes, each with a saturating occurrence counter readable via a select port.
- Drops and flags any other message type.

---
 rtl/event_broker_mc.sv | 110 +++++++++++
 1 files changed

// File: rtl/event_broker_mc.sv
// event_broker_mc: multi-channel message broker with a buffered response path.
// Consumes inbound AXI-Stream messages; type 0 responses are queued in a FIFO
// and replayed on AXIS_OUT, type 1 events raise one-cycle per-channel strobes
// and bump saturating counters, and anything else pulses bad_msg.
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   AXIS_IN_*                inbound message stream (TREADY registered-state only)
//   AXIS_OUT_*               response stream, head of the response FIFO
//   event_strobe, bad_msg    registered one-cycle pulses per accepted message
//   cnt_sel, cnt_value       combinational per-channel counter readback
//   cnt_clear                synchronous clear of all counters
//   rsp_level                response FIFO occupancy
module event_broker_mc #(
    parameter int DATA_WIDTH  = 256,
    parameter int EVENT_COUNT = 8,
    parameter int RSP_DEPTH   = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [DATA_WIDTH-1:0]        AXIS_IN_TDATA,
    input  logic                         AXIS_IN_TVALID,
    output logic                         AXIS_IN_TREADY,
    output logic [DATA_WIDTH-1:0]        AXIS_OUT_TDATA,
    output logic                         AXIS_OUT_TVALID,
    input  logic                         AXIS_OUT_TREADY,
    output logic [EVENT_COUNT-1:0]       event_strobe,
    output logic                         bad_msg,
    input  logic [7:0]                   cnt_sel,
    output logic [CNT_WIDTH-1:0]         cnt_value,
    input  logic                         cnt_clear,
    output logic [$clog2(RSP_DEPTH):0]   rsp_level
);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           level_q, level_d;
    logic [EVENT_COUNT-1:0]  event_strobe_q, event_strobe_d;
    logic                    bad_msg_q, bad_msg_d;
    logic [CNT_WIDTH-1:0]    cnt_q [EVENT_COUNT];
    logic [CNT_WIDTH-1:0]    cnt_d [EVENT_COUNT];
    logic [DATA_WIDTH-1:0]   mem [RSP_DEPTH];
    logic [7:0]              msg_type, evt;
    logic                    accept, push, pop, evt_ok;

    assign msg_type        = AXIS_IN_TDATA[DATA_WIDTH-1 -: 8];
    assign evt             = AXIS_IN_TDATA[7:0];
    assign evt_ok          = (evt != 8'd0) && (evt <= 8'(EVENT_COUNT));
    // Full is judged from the registered level only, so a pop in this cycle
    // cannot open the input side combinationally.
    assign AXIS_IN_TREADY  = (state_q == RUN) && (level_q != LW'(RSP_DEPTH));
    assign accept          = AXIS_IN_TVALID && AXIS_IN_TREADY;
    assign push            = accept && (msg_type == 8'd0);
    assign AXIS_OUT_TVALID = (level_q != '0);
    assign pop             = AXIS_OUT_TVALID && AXIS_OUT_TREADY;
    assign AXIS_OUT_TDATA  = mem[rd_ptr_q];
    assign rsp_level       = level_q;
    assign event_strobe    = event_strobe_q;
    assign bad_msg         = bad_msg_q;

    always_comb begin
        state_d   = RUN;
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        level_d   = level_q + LW'(push) - LW'(pop);
        bad_msg_d = accept && ((msg_type == 8'd1) ? !evt_ok : (msg_type != 8'd0));
        for (int k = 0; k < EVENT_COUNT; k++) begin
            event_strobe_d[k] = accept && (msg_type == 8'd1) && (evt == 8'(k + 1));
            // Clear wins over a same-cycle increment; increments stop at all-ones.
            cnt_d[k] = cnt_clear ? '0 :
                       (event_strobe_d[k] && (cnt_q[k] != '1)) ? cnt_q[k] + CNT_WIDTH'(1) :
                       cnt_q[k];
        end
    end

    always_comb begin
        cnt_value = '0;
        for (int k = 0; k < EVENT_COUNT; k++)
            if (cnt_sel == 8'(k)) cnt_value = cnt_q[k];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= INIT;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            event_strobe_q <= '0;
            bad_msg_q      <= 1'b0;
            for (int k = 0; k < EVENT_COUNT; k++) cnt_q[k] <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            event_strobe_q <= event_strobe_d;
            bad_msg_q      <= bad_msg_d;
            for (int k = 0; k < EVENT_COUNT; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    // Payload storage needs no reset; validity is carried by level_q.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= AXIS_IN_TDATA;
    end
endmodule
